// File: rtl/ce_rate_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// ce_rate_sequencer_pkg : shared types, rate codes and helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ce_rate_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned RATE_W   = 4;
  localparam logic [3:0]  RATE_MAX = 4'd14;

  // Rate code k selects a strobe at 32.768 MHz / 2^(k+1)
  localparam logic [3:0]  RATE_16M = 4'd0;
  localparam logic [3:0]  RATE_1M  = 4'd4;
  localparam logic [3:0]  RATE_64K = 4'd8;
  localparam logic [3:0]  RATE_16K = 4'd10;
  localparam logic [3:0]  RATE_4K  = 4'd12;
  localparam logic [3:0]  RATE_1K  = 4'd14;

  function automatic logic [3:0] max_rate(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_rate_sequencer_if.sv
// ----------------------------------------------------------------------------
// ce_rate_sequencer_if : enable bus, config handshake and tick outputs
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ce_rate_sequencer_if
  import ce_rate_sequencer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int N_RATES = 15
);

  logic [N_RATES-1:0] ce_bus;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [RATE_W-1:0]  cfg_rate;
  logic [CNT_W-1:0]   cfg_count;
  logic               start;
  logic               stop;
  logic               busy;
  logic               tick;
  logic [CNT_W-1:0]   tick_idx;
  logic               done;
  logic               cfg_err;

  modport master (
    output ce_bus, cfg_valid, cfg_rate, cfg_count, start, stop,
    input  cfg_ready, busy, tick, tick_idx, done, cfg_err
  );

  modport slave (
    input  ce_bus, cfg_valid, cfg_rate, cfg_count, start, stop,
    output cfg_ready, busy, tick, tick_idx, done, cfg_err
  );

endinterface

`default_nettype wire

// File: rtl/ce_rate_sequencer.sv
// ----------------------------------------------------------------------------
// ce_rate_sequencer : rate-selected, phase-aligned gated tick burst generator
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ce_rate_sequencer
  import ce_rate_sequencer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int N_RATES = 15
)(
  input  wire logic             clk32M768,
  input  wire logic             rst_n,
  ce_rate_sequencer_if.slave    sq_if
);

  state_e            state_q, state_d;
  logic [3:0]        rate_cur_q, rate_cur_d;
  logic [3:0]        rate_new_q, rate_new_d;
  logic [CNT_W-1:0]  count_cur_q, count_cur_d;
  logic [CNT_W-1:0]  count_new_q, count_new_d;
  logic              pending_q, pending_d;
  logic              cnt_new_q, cnt_new_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  tick_idx_q, tick_idx_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic xfer_w, rate_ok_w, take_w, ev_w, apply_w, end_burst_w;

  function automatic logic ce_sel(input logic [N_RATES-1:0] ce, input logic [3:0] code);
    logic r;
    r = 1'b0;
    for (int k = 0; k < N_RATES; k++) begin
      if (code == 4'(k)) r = ce[k];
    end
    return r;
  endfunction

  assign xfer_w    = sq_if.cfg_valid && !pending_q;
  assign rate_ok_w = (sq_if.cfg_rate <= RATE_MAX);
  assign take_w    = xfer_w && rate_ok_w;
  assign ev_w      = ce_sel(sq_if.ce_bus, rate_cur_q);
  // The slower of old/new strobes marks a boundary shared by both rates
  assign apply_w   = pending_q && ce_sel(sq_if.ce_bus, max_rate(rate_cur_q, rate_new_q));

  always_comb begin
    state_d     = state_q;
    rate_cur_d  = rate_cur_q;
    rate_new_d  = rate_new_q;
    count_cur_d = count_cur_q;
    count_new_d = count_new_q;
    pending_d   = pending_q;
    cnt_new_d   = cnt_new_q;
    idx_d       = idx_q;
    tick_idx_d  = tick_idx_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    cfg_err_d   = xfer_w && !rate_ok_w;
    end_burst_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_w) begin
          rate_cur_d  = sq_if.cfg_rate;
          count_cur_d = sq_if.cfg_count;
        end
        if (sq_if.start) begin
          state_d    = ST_ARM;
          idx_d      = '0;
          tick_idx_d = '0;
        end
      end
      ST_ARM, ST_RUN: begin
        if (sq_if.stop) begin
          end_burst_w = 1'b1;
        end else begin
          if (take_w) begin
            rate_new_d  = sq_if.cfg_rate;
            count_new_d = sq_if.cfg_count;
            pending_d   = 1'b1;
            cnt_new_d   = 1'b1;
          end
          if (ev_w) begin
            state_d    = ST_RUN;
            tick_d     = 1'b1;
            tick_idx_d = idx_q;
            idx_d      = idx_q + 1'b1;
            if (apply_w) begin
              rate_cur_d = rate_new_q;
              pending_d  = 1'b0;
            end
            if ((count_cur_q != '0) && (idx_q == count_cur_q - 1'b1)) begin
              done_d      = 1'b1;
              end_burst_w = 1'b1;
            end
          end
        end
        // Leaving the burst folds any stored config into the live settings
        if (end_burst_w) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
          cnt_new_d = 1'b0;
          if (take_w) begin
            rate_cur_d  = sq_if.cfg_rate;
            count_cur_d = sq_if.cfg_count;
          end else begin
            if (pending_q) rate_cur_d  = rate_new_q;
            if (cnt_new_q) count_cur_d = count_new_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk32M768 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rate_cur_q  <= RATE_16M;
      rate_new_q  <= RATE_16M;
      count_cur_q <= '0;
      count_new_q <= '0;
      pending_q   <= 1'b0;
      cnt_new_q   <= 1'b0;
      idx_q       <= '0;
      tick_idx_q  <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rate_cur_q  <= rate_cur_d;
      rate_new_q  <= rate_new_d;
      count_cur_q <= count_cur_d;
      count_new_q <= count_new_d;
      pending_q   <= pending_d;
      cnt_new_q   <= cnt_new_d;
      idx_q       <= idx_d;
      tick_idx_q  <= tick_idx_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign sq_if.cfg_ready = !pending_q;
  assign sq_if.busy      = (state_q != ST_IDLE);
  assign sq_if.tick      = tick_q;
  assign sq_if.tick_idx  = tick_idx_q;
  assign sq_if.done      = done_q;
  assign sq_if.cfg_err   = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ce_rate_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ce_rate_sequencer : randomized scoreboard bench with a timestamp model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ce_rate_sequencer;

  localparam int CNT_W   = 10;
  localparam int N_RATES = 15;

  typedef struct {
    int unsigned      ts;
    logic [CNT_W-1:0] idx;
    bit               fin;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  int          m_rate  = 0;
  int          m_count = 0;
  exp_t        sb[$];
  int unsigned errq[$];
  exp_t        e;

  ce_rate_sequencer_if #(.CNT_W(CNT_W), .N_RATES(N_RATES)) bus ();

  ce_rate_sequencer #(.CNT_W(CNT_W), .N_RATES(N_RATES)) dut (
    .clk32M768 (clk),
    .rst_n     (rst_n),
    .sq_if     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: strobe k is high whenever the low k+1 cycle bits are zero
  for (genvar k = 0; k < N_RATES; k++) begin : g_ce
    assign bus.ce_bus[k] = (cyc[k:0] == '0);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned nm(input int unsigned v, input int rate);
    int unsigned p;
    p = 32'd1 << (rate + 1);
    return ((v + p - 1) / p) * p;
  endfunction

  // Expected ticks: events on multiples of the rate period, switching period after the apply point
  task automatic plan(input int unsigned s, input int rate, input int count, input bit chg,
                      input int unsigned a, input int new_rate, input bit stp,
                      input int unsigned y, output int unsigned endc);
    int unsigned v;
    int r;
    int i;
    bit fin;
    bit stopflag;
    v = nm(s + 1, rate);
    r = rate;
    i = 0;
    stopflag = 1'b0;
    endc = 0;
    while (!stopflag) begin
      if (stp && v >= y) begin
        endc = y;
        stopflag = 1'b1;
      end else begin
        fin = (count != 0) && (i == count - 1);
        sb.push_back('{ts: v + 1, idx: CNT_W'(i), fin: fin});
        i++;
        if (fin || i > 4096) begin
          endc = v;
          stopflag = 1'b1;
        end else begin
          if (chg && v >= a) r = new_rate;
          v = nm(v + 1, r);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tick) begin
        if (sb.size() == 0) begin
          chk("tick_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("tick_cycle", cyc, e.ts);
          chk("tick_idx", bus.tick_idx, e.idx);
          chk("done_on_tick", bus.done, e.fin);
          chk("busy_on_tick", bus.busy, !e.fin);
        end
      end else begin
        if (bus.done) chk("done_without_tick", 1, 0);
        if (sb.size() != 0 && sb[0].ts <= cyc) begin
          chk("tick_missing", 0, 1);
          sb.delete(0);
        end
      end
      if (bus.cfg_err) begin
        if (errq.size() == 0) chk("cfg_err_unexpected", 1, 0);
        else chk("cfg_err_cycle", cyc, errq.pop_front());
      end else if (errq.size() != 0 && errq[0] <= cyc) begin
        chk("cfg_err_missing", 0, 1);
        errq.delete(0);
      end
    end
  end

  task automatic cfg(input int rate, input int cnt);
    int unsigned x;
    x = cyc;
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_rate  = 4'(rate);
    bus.cfg_count = CNT_W'(cnt);
    if (rate > 14) begin
      errq.push_back(x + 1);
    end else begin
      m_rate  = rate;
      m_count = cnt;
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    if (rate > 14) chk("cfg_ready_after_err", bus.cfg_ready, 1);
    @(negedge clk);
  endtask

  task automatic burst(input bit chg, input int new_rate, input int new_cnt,
                       input int chg_dly, input int stop_dly);
    int unsigned s, x, y, a, endc, lo_end, last_c;
    bit stp;
    stp = (stop_dly != 0);
    s = cyc;
    x = s + chg_dly;
    y = s + stop_dly;
    a = chg ? nm(x + 1, (new_rate > m_rate) ? new_rate : m_rate) : 32'hFFFF_FFFF;
    plan(s, m_rate, m_count, chg, a, new_rate, stp, y, endc);
    lo_end = (a < endc) ? a : endc;
    last_c = endc + 3;
    if (chg && x + 2 > last_c) last_c = x + 2;
    for (int unsigned c = s; c <= last_c; c++) begin
      bus.start     = (c == s);
      bus.cfg_valid = chg && (c == x);
      bus.cfg_rate  = 4'(new_rate);
      bus.cfg_count = CNT_W'(new_cnt);
      bus.stop      = stp && (c == y);
      if (chg && x + 1 <= lo_end) begin
        if (c == x + 1)      chk("cfg_ready_pending", bus.cfg_ready, 0);
        if (c == lo_end + 1) chk("cfg_ready_released", bus.cfg_ready, 1);
      end
      if (stp && endc == y && c == y + 1) chk("busy_after_stop", bus.busy, 0);
      @(negedge clk);
    end
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.stop      = 1'b0;
    chk("sb_drain", sb.size(), 0);
    chk("busy_end", bus.busy, 0);
    if (chg) begin
      m_rate  = new_rate;
      m_count = new_cnt;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned s, c, endc;
    int r, cnt, nr, nc, cd, sd;
    bit chg;
    bus.cfg_valid = 1'b0;
    bus.cfg_rate  = '0;
    bus.cfg_count = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tick", bus.tick, 0);
    chk("rst_tick_idx", bus.tick_idx, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic burst: rate 3, four ticks
    cfg(3, 4);
    burst(0, 0, 0, 0, 0);

    // Invalid rate: error pulse, config unchanged
    cfg(15, 7);
    burst(0, 0, 0, 0, 0);

    // Free run at rate 0 across the tick index wrap, stopped on an event cycle
    cfg(0, 0);
    burst(0, 0, 0, 0, 2200 + int'(cyc & 1));

    // Mid-burst slow-down 2 -> 5, new count used by the following burst
    cfg(2, 20);
    burst(1, 5, 4, 5, 0);
    burst(0, 0, 0, 0, 0);

    // Stop on an event cycle while a rate change is still pending
    cfg(1, 0);
    for (int k = 0; k < 200 && (cyc % 128) != 1; k++) @(negedge clk);
    burst(1, 6, 3, 3, 11);
    burst(0, 0, 0, 0, 0);

    for (int n = 0; n < 8; n++) begin
      r   = int'($urandom_range(0, 4));
      cnt = int'($urandom_range(1, 6));
      if ($urandom_range(0, 4) == 0) cnt = 0;
      cfg(r, cnt);
      chg = bit'($urandom_range(0, 1));
      nr  = int'($urandom_range(0, 6));
      nc  = int'($urandom_range(1, 6));
      cd  = int'($urandom_range(1, 40));
      sd  = (cnt == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(2, 150)) : 0;
      burst(chg, nr, nc, cd, sd);
    end

    // Asynchronous reset mid-burst while a tick is on the output
    cfg(2, 0);
    s = cyc;
    c = nm(s + 20, 2) + 1;
    plan(s, 2, 0, 1'b0, 0, 0, 1'b1, c, endc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 100 && cyc < c; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", bus.tick, 0);
    chk("arst_tick_idx", bus.tick_idx, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_cfg_err", bus.cfg_err, 0);
    chk("arst_cfg_ready", bus.cfg_ready, 1);
    chk("arst_sb_empty", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_rate  = 0;
    m_count = 0;
    @(negedge clk);
    burst(0, 0, 0, 0, 21);

    repeat (4) @(negedge clk);
    chk("err_queue_empty", errq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
